// File: rtl/relu_pack_acc.sv
// Accumulator output stage: arithmetic shift with optional rounding, ReLU/linear clamp to OUT_W,
// then packing of PACK beats per output word behind valid/ready, with a saturation event counter.
module relu_pack_acc #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned PACK    = 2,
    parameter int unsigned SHIFT_W = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SHIFT_W-1:0]          acc_shift,
    input  logic                        relu_en,
    input  logic                        rnd_en,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*ACC_W-1:0]      in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [PACK*LANES*OUT_W-1:0] out_data,
    output logic [PACK-1:0]             out_keep,
    output logic                        out_last,
    input  logic                        sat_clr,
    output logic [15:0]                 sat_cnt
);
    localparam int unsigned EXT_W  = ACC_W + 1;
    localparam int unsigned BEAT_W = LANES * OUT_W;
    localparam int unsigned WORD_W = PACK * BEAT_W;
    localparam int unsigned CNT_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned SAT_W  = $clog2(LANES + 1);

    localparam logic signed [EXT_W-1:0] U_MAX = EXT_W'((64'd1 << OUT_W) - 64'd1);
    localparam logic signed [EXT_W-1:0] S_MAX = EXT_W'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [EXT_W-1:0] S_MIN = ~S_MAX;

    logic                    adv;
    logic signed [EXT_W-1:0] rnd_c;
    logic signed [EXT_W-1:0] sh_c [LANES];
    logic signed [EXT_W-1:0] s1_lane [LANES];
    logic                    s1_relu, s1_last, s1_valid;
    logic [BEAT_W-1:0]       clamp_c;
    logic [SAT_W-1:0]        sat_c;
    logic [BEAT_W-1:0]       s2_data;
    logic [SAT_W-1:0]        s2_sat;
    logic                    s2_last, s2_valid;
    logic [CNT_W-1:0]        cnt;
    logic [PACK-1:0]         keep_c;
    logic                    close_c;
    logic [16:0]             sat_add_c;
    logic [15:0]             sat_next_c;

    // Whole pipe stalls only while a finished word waits for the consumer.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    // Sign-extend one bit so the rounding add cannot overflow before the shift.
    always_comb begin
        rnd_c = '0;
        if (rnd_en && (acc_shift != '0)) begin
            rnd_c = EXT_W'(1) << (acc_shift - SHIFT_W'(1));
        end
        for (int i = 0; i < LANES; i++) begin
            sh_c[i] = ($signed({in_data[i*ACC_W+ACC_W-1], in_data[i*ACC_W +: ACC_W]}) + rnd_c)
                      >>> acc_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_relu  <= 1'b0;
            for (int i = 0; i < LANES; i++) s1_lane[i] <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_last  <= in_last;
            s1_relu  <= relu_en;
            for (int i = 0; i < LANES; i++) s1_lane[i] <= sh_c[i];
        end
    end

    // Negative results under ReLU clamp to zero silently; only range overflows count.
    always_comb begin
        sat_c   = '0;
        clamp_c = '0;
        for (int i = 0; i < LANES; i++) begin
            clamp_c[i*OUT_W +: OUT_W] = s1_lane[i][OUT_W-1:0];
            if (s1_relu) begin
                if (s1_lane[i][EXT_W-1]) begin
                    clamp_c[i*OUT_W +: OUT_W] = '0;
                end else if (s1_lane[i] > U_MAX) begin
                    clamp_c[i*OUT_W +: OUT_W] = U_MAX[OUT_W-1:0];
                    sat_c = sat_c + SAT_W'(1);
                end
            end else if (s1_lane[i] > S_MAX) begin
                clamp_c[i*OUT_W +: OUT_W] = S_MAX[OUT_W-1:0];
                sat_c = sat_c + SAT_W'(1);
            end else if (s1_lane[i] < S_MIN) begin
                clamp_c[i*OUT_W +: OUT_W] = S_MIN[OUT_W-1:0];
                sat_c = sat_c + SAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_data  <= '0;
            s2_sat   <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_data  <= clamp_c;
            s2_sat   <= sat_c;
        end
    end

    always_comb begin
        close_c = (cnt == CNT_W'(PACK - 1)) || s2_last;
        keep_c  = '0;
        for (int s = 0; s < PACK; s++) keep_c[s] = (CNT_W'(s) <= cnt);
        sat_add_c  = {1'b0, sat_cnt} + 17'(s2_sat);
        sat_next_c = sat_add_c[16] ? 16'hFFFF : sat_add_c[15:0];
    end

    // Packer: slot 0 of a new word wipes the rest so unfilled slots read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            cnt       <= '0;
            sat_cnt   <= '0;
        end else begin
            if (sat_clr) begin
                sat_cnt <= '0;
            end else if (adv && s2_valid) begin
                sat_cnt <= sat_next_c;
            end
            if (adv) begin
                if (s2_valid) begin
                    if (cnt == '0) begin
                        out_data <= WORD_W'(s2_data);
                    end else begin
                        for (int s = 1; s < PACK; s++) begin
                            if (cnt == CNT_W'(s)) out_data[s*BEAT_W +: BEAT_W] <= s2_data;
                        end
                    end
                    if (close_c) begin
                        out_valid <= 1'b1;
                        out_keep  <= keep_c;
                        out_last  <= s2_last;
                        cnt       <= '0;
                    end else begin
                        out_valid <= 1'b0;
                        if (cnt == '0) out_keep <= '0;
                        cnt <= cnt + CNT_W'(1);
                    end
                end else if (out_valid) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_relu_pack_acc.sv
// Randomised and directed bench for relu_pack_acc against a word-level reference model.
module tb_relu_pack_acc;
    localparam int unsigned LANES   = 4;
    localparam int unsigned ACC_W   = 32;
    localparam int unsigned OUT_W   = 8;
    localparam int unsigned PACK    = 2;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned WORD_W  = PACK * LANES * OUT_W;
    localparam int unsigned IN_W    = LANES * ACC_W;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [SHIFT_W-1:0] acc_shift;
    logic               relu_en, rnd_en, in_valid, in_ready, in_last;
    logic               out_valid, out_ready, out_last, sat_clr;
    logic [IN_W-1:0]    in_data;
    logic [WORD_W-1:0]  out_data;
    logic [PACK-1:0]    out_keep;
    logic [15:0]        sat_cnt;

    relu_pack_acc #(.LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .PACK(PACK), .SHIFT_W(SHIFT_W)) dut (
        .clk(clk), .rst_n(rst_n), .acc_shift(acc_shift), .relu_en(relu_en), .rnd_en(rnd_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
        .out_last(out_last), .sat_clr(sat_clr), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    int                n_vec = 0;
    int                n_bad = 0;
    logic [WORD_W-1:0] exp_data_q[$];
    logic [PACK-1:0]   exp_keep_q[$];
    logic              exp_last_q[$];
    logic [WORD_W-1:0] part_data = '0;
    int                part_n = 0;
    int                sat_model = 0;
    int                words_seen = 0;
    bit                mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference lane: plain integer shift/round followed by range clamp.
    function automatic logic [OUT_W-1:0] ref_lane(input logic [ACC_W-1:0] x, input int sh,
                                                  input bit rnd, input bit relu, output bit sat);
        longint v, hi, lo;
        v = longint'($signed(x));
        if (rnd && sh > 0) v = v + (longint'(1) << (sh - 1));
        v  = v >>> sh;
        hi = relu ? (longint'(1) << OUT_W) - 1 : (longint'(1) << (OUT_W - 1)) - 1;
        lo = relu ? 0 : -(longint'(1) << (OUT_W - 1));
        sat = (v > hi) || (!relu && v < lo);
        if (v > hi) v = hi;
        else if (v < lo) v = lo;
        return OUT_W'(v);
    endfunction

    task automatic model_accept(input logic [IN_W-1:0] d, input int sh, input bit rnd,
                                input bit relu, input bit last);
        bit s;
        for (int i = 0; i < LANES; i++) begin
            part_data[(part_n*LANES+i)*OUT_W +: OUT_W] = ref_lane(d[i*ACC_W +: ACC_W], sh, rnd, relu, s);
            if (s && sat_model < 32'hFFFF) sat_model++;
        end
        part_n++;
        if (last || part_n == PACK) begin
            exp_data_q.push_back(part_data);
            exp_keep_q.push_back(PACK'((1 << part_n) - 1));
            exp_last_q.push_back(last);
            part_data = '0;
            part_n    = 0;
        end
    endtask

    task automatic model_clear();
        exp_data_q.delete();
        exp_keep_q.delete();
        exp_last_q.delete();
        part_data = '0;
        part_n    = 0;
        sat_model = 0;
    endtask

    // Monitor on the falling edge: inputs and outputs are stable here.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (out_valid) begin
                if (exp_data_q.size() == 0) begin
                    check("unexpected_word", 64'(out_valid), 64'(0));
                end else begin
                    check("out_data", out_data, exp_data_q[0]);
                    check("out_keep", 64'(out_keep), 64'(exp_keep_q[0]));
                    check("out_last", 64'(out_last), 64'(exp_last_q[0]));
                    if (out_ready) begin
                        void'(exp_data_q.pop_front());
                        void'(exp_keep_q.pop_front());
                        void'(exp_last_q.pop_front());
                        words_seen++;
                    end
                end
            end
            if (in_valid && in_ready) model_accept(in_data, int'(acc_shift), rnd_en, relu_en, in_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [IN_W-1:0] d, input int sh, input bit rnd,
                              input bit relu, input bit last);
        int guard = 0;
        in_data = d; acc_shift = SHIFT_W'(sh); rnd_en = rnd; relu_en = relu; in_last = last;
        in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (guard >= 100) check("accept_timeout", 64'(guard), 64'(0));
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (8) tick();
    endtask

    function automatic logic [IN_W-1:0] rand_data();
        logic [IN_W-1:0]  d;
        logic [ACC_W-1:0] v;
        for (int i = 0; i < LANES; i++) begin
            v = ACC_W'($urandom >> $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) v = -v;
            d[i*ACC_W +: ACC_W] = v;
        end
        return d;
    endfunction

    task automatic run_stream(input int nbeats, input int stall_at, input int stall_len, input bit rand_mode);
        int sent = 0;
        int c = 0;
        while (sent < nbeats && c < 5000) begin
            out_ready = rand_mode ? ($urandom_range(0, 9) < 7) : !(c >= stall_at && c < stall_at + stall_len);
            in_valid  = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data   = rand_data();
            acc_shift = SHIFT_W'($urandom_range(0, 31));
            rnd_en    = 1'($urandom_range(0, 1));
            relu_en   = 1'($urandom_range(0, 1));
            in_last   = rand_mode ? ($urandom_range(0, 4) == 0) : 1'b0;
            #1;
            if (in_valid && in_ready) sent++;
            tick();
            c++;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        check("stream_beats", 64'(sent), 64'(nbeats));
    endtask

    initial begin
        int n;
        int w0;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; acc_shift = '0;
        rnd_en = 1'b0; relu_en = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", out_data, 64'(0));
        check("rst_out_keep", 64'(out_keep), 64'(0));
        check("rst_out_last", 64'(out_last), 64'(0));
        check("rst_sat_cnt", 64'(sat_cnt), 64'(0));
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'(1));

        // ReLU clamp, two-beat word, latency from presentation of the closing beat
        drive_beat({32'h0000000F, 32'h00010000, 32'hFFFFFF00, 32'h00000130}, 4, 0, 1, 0);
        drive_beat({32'h00000500, 32'h00000010, 32'h00000000, 32'h000007F0}, 4, 0, 1, 0);
        wait_out(n);
        check("relu_latency", 64'(n + 1), 64'(3));
        check("relu_data", out_data, 64'h5001007F_00FF0013);
        check("relu_keep", 64'(out_keep), 64'(2'b11));
        check("relu_last", 64'(out_last), 64'(0));
        drain();
        check("relu_sat", 64'(sat_cnt), 64'(1));

        // Rounding, flushed by in_last as a single-slot word
        drive_beat({32'h00000000, 32'hFFFFFFE8, 32'h00000017, 32'h00000018}, 4, 1, 0, 1);
        wait_out(n);
        check("rnd_data", out_data, 64'h00000000_00FF0102);
        check("rnd_keep", 64'(out_keep), 64'(2'b01));
        check("rnd_last", 64'(out_last), 64'(1));
        tick();
        drive_beat({32'h0, 32'h0, 32'h0, 32'h00000018}, 4, 0, 0, 1);
        wait_out(n);
        check("trunc_data", out_data, 64'h00000000_00000001);
        check("trunc_keep", 64'(out_keep), 64'(2'b01));
        drain();

        // Linear clamp both directions, then clear racing a saturating beat
        drive_beat({32'h0, 32'h0, 32'hFFFFF000, 32'h00001000}, 0, 0, 0, 1);
        wait_out(n);
        check("lin_data", out_data, 64'h00000000_0000807F);
        drain();
        check("lin_sat", 64'(sat_cnt), 64'(3));
        drive_beat({32'h0, 32'h0, 32'hFFFFF000, 32'h00001000}, 0, 0, 0, 1);
        tick();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sat_clr_wins", 64'(sat_cnt), 64'(0));
        sat_model = 0;
        drain();

        // Backpressure: 10 beats, consumer stalls 5 cycles mid-stream
        w0 = words_seen;
        run_stream(10, 3, 5, 1'b0);
        drain();
        check("bp_words", 64'(words_seen - w0), 64'(5));
        check("bp_sat", 64'(sat_cnt), 64'(sat_model));

        // Random traffic with random consumer, closed by a final last beat
        run_stream(300, 0, 0, 1'b1);
        drive_beat(rand_data(), 3, 1, 1, 1);
        drain();
        check("rand_sat", 64'(sat_cnt), 64'(sat_model));
        check("rand_drained", 64'(exp_data_q.size()), 64'(0));

        // Reset with a partial word in flight
        drive_beat({4{32'h00000100}}, 4, 0, 1, 0);
        rst_n = 1'b0;
        model_clear();
        tick();
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_sat", 64'(sat_cnt), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        drive_beat({32'h00000400, 32'h00000300, 32'h00000200, 32'h00000100}, 4, 0, 1, 0);
        drive_beat({32'h00000080, 32'h00000070, 32'h00000060, 32'h00000050}, 4, 0, 1, 0);
        wait_out(n);
        check("mid_rst_data", out_data, 64'h08070605_40302010);
        check("mid_rst_keep", 64'(out_keep), 64'(2'b11));
        drain();
        check("final_drained", 64'(exp_data_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
